// File: rtl/clock_period_meter.sv
// ============================================================================
// Module   : clock_period_meter
// Brief    : Measures the half-period of a slow asynchronous square wave in
//            clk cycles, recovers the scaler value, and flags lock and loss.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clock_period_meter #(
  parameter int COUNT_WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] half_period,
  output logic [COUNT_WIDTH-1:0] scaler_est,
  output logic                   meas_valid,
  output logic                   locked,
  output logic                   timeout
);

  localparam int c_match_w = $clog2(LOCK_COUNT + 1);
  localparam logic [COUNT_WIDTH-1:0] c_cnt_max  = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] c_cnt_near = {{(COUNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [COUNT_WIDTH-1:0] c_one      = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [c_match_w-1:0]   c_match_one  = c_match_w'(1);
  localparam logic [c_match_w-1:0]   c_match_lock = c_match_w'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     sync_prev_q;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]   half_period_q, half_period_d;
  logic [COUNT_WIDTH-1:0]   scaler_est_q, scaler_est_d;
  logic                     meas_valid_q, meas_valid_d;
  logic                     locked_q, locked_d;
  logic                     timeout_q, timeout_d;
  logic [c_match_w-1:0]     match_q, match_d;
  logic                     first_q, first_d;

  logic                     w_edge;
  logic                     w_sat;
  logic [COUNT_WIDTH:0]     w_meas_wide;
  logic [COUNT_WIDTH-1:0]   w_meas;
  logic [c_match_w-1:0]     w_match_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign w_edge      = sync_q[SYNC_STAGES-1] ^ sync_prev_q;
  assign w_meas_wide = {1'b0, cnt_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
  assign w_meas      = w_meas_wide[COUNT_WIDTH] ? c_cnt_max : w_meas_wide[COUNT_WIDTH-1:0];
  // Counter hits all-ones on this cycle's increment (or already sits there).
  assign w_sat       = (cnt_q >= c_cnt_near);

  always_comb begin
    state_d       = state_q;
    half_period_d = half_period_q;
    scaler_est_d  = scaler_est_q;
    meas_valid_d  = 1'b0;
    locked_d      = locked_q;
    timeout_d     = timeout_q;
    match_d       = match_q;
    first_d       = first_q;
    w_match_next  = c_match_one;

    if (w_edge) begin
      cnt_d = '0;
    end else if (cnt_q != c_cnt_max) begin
      cnt_d = cnt_q + c_one;
    end else begin
      cnt_d = cnt_q;
    end

    if (!first_q && (w_meas == half_period_q)) begin
      w_match_next = match_q + c_match_one;
    end

    case (state_q)
      IDLE: begin
        if (w_edge) begin
          timeout_d = 1'b0;
          first_d   = 1'b1;
          match_d   = '0;
          state_d   = MEASURE;
        end
      end
      MEASURE: begin
        if (w_edge) begin
          half_period_d = w_meas;
          scaler_est_d  = w_meas - c_one;
          meas_valid_d  = 1'b1;
          first_d       = 1'b0;
          match_d       = w_match_next;
          if (w_match_next == c_match_lock) begin
            locked_d = 1'b1;
            state_d  = LOCKED;
          end
        end else if (w_sat) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
          state_d   = IDLE;
        end
      end
      LOCKED: begin
        if (w_edge) begin
          half_period_d = w_meas;
          scaler_est_d  = w_meas - c_one;
          meas_valid_d  = 1'b1;
          if (w_meas != half_period_q) begin
            locked_d = 1'b0;
            match_d  = c_match_one;
            state_d  = MEASURE;
          end
        end else if (w_sat) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      half_period_q <= '0;
      scaler_est_q  <= '0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
      match_q       <= '0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_period_q <= half_period_d;
      scaler_est_q  <= scaler_est_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
      match_q       <= match_d;
      first_q       <= first_d;
    end
  end

  assign half_period = half_period_q;
  assign scaler_est  = scaler_est_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule

`default_nettype wire
